pipelined_adder: RTL

Parametrised, pipelined add/subtract unit with a valid/ready handshake, replacing the flat 32-bit combinational adder wherever the sum sits on a critical path (branch-target, address generation, multi-cycle ALU datapath). Operands are split into `STAGES` equal chunks. One chunk is added per pipeline stage, with the carry registered between stages. Throughput is one operation per cycle. Each result also carries carry-out, signed-overflow and zero flags.

---
 rtl/pipelined_adder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: add/subtract unit split into STAGES equal chunks. Each
// chunk is added in its own register stage and the carry is registered
// between stages. The unit takes one operation per cycle, has a valid/ready
// handshake and a single global stall.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   in_valid       operand set on a/b/sub is valid
//   in_ready       unit accepts an operand set this cycle (= !out_valid || out_ready)
//   a, b, sub      operands; sub=1 computes a - b as a + ~b + 1
//   out_valid      result fields are valid
//   out_ready      downstream takes the result this cycle
//   y              result modulo 2^WIDTH
//   cout           carry out of the MSB (for subtract, 1 = no borrow)
//   overflow       two's-complement signed overflow
//   zero           y == 0, decoded from the output register

// One chunk of the carry chain. The stage adds operand chunk IDX plus the
// incoming carry and drops the sum into slot IDX of the travelling result.
// The operands pass through unchanged so that later stages can pick up
// their own chunks.
module pipelined_adder_stage #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_c,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_y,
    output logic             out_c
);
    localparam int LO = IDX * CHUNK;

    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] y_next;
    logic             unused_slot;

    always_comb begin
        sum            = {1'b0, in_a[LO +: CHUNK]} + {1'b0, in_b[LO +: CHUNK]}
                       + {{CHUNK{1'b0}}, in_c};
        y_next         = in_y;
        y_next[LO +: CHUNK] = sum[CHUNK-1:0];
    end

    // This stage fills the slot, so the incoming contents of that slot are never read.
    assign unused_slot = ^in_y[LO +: CHUNK];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_a   <= '0;
            out_b   <= '0;
            out_y   <= '0;
            out_c   <= 1'b0;
        end else if (adv) begin
            out_vld <= in_vld;
            out_a   <= in_a;
            out_b   <= in_b;
            out_y   <= y_next;
            out_c   <= sum[CHUNK];
        end
    end
endmodule

module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    generate
        if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_param
            $error("pipelined_adder: STAGES must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    localparam int CHUNK = WIDTH / STAGES;

    // Index 0 is the accepted operand set (combinational). Index k is the
    // register of stage k.
    logic [STAGES:0]            vld_pipe;
    logic [STAGES:0]            c_pipe;
    logic [STAGES:0][WIDTH-1:0] a_pipe;
    logic [STAGES:0][WIDTH-1:0] b_pipe;
    logic [STAGES:0][WIDTH-1:0] y_pipe;

    logic adv;
    logic unused_ops;

    // Global stall: the whole pipe moves only when the output slot is free or draining.
    assign adv      = !vld_pipe[STAGES] || out_ready;
    assign in_ready = adv;

    // Subtract is formed at acceptance: invert b here and feed sub into the first carry.
    assign vld_pipe[0] = in_valid;
    assign a_pipe[0]   = a;
    assign b_pipe[0]   = b ^ {WIDTH{sub}};
    assign y_pipe[0]   = '0;
    assign c_pipe[0]   = sub;

    genvar s;
    generate
        for (s = 0; s < STAGES; s++) begin : g_stage
            pipelined_adder_stage #(
                .WIDTH (WIDTH),
                .CHUNK (CHUNK),
                .IDX   (s)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .adv     (adv),
                .in_vld  (vld_pipe[s]),
                .in_a    (a_pipe[s]),
                .in_b    (b_pipe[s]),
                .in_y    (y_pipe[s]),
                .in_c    (c_pipe[s]),
                .out_vld (vld_pipe[s+1]),
                .out_a   (a_pipe[s+1]),
                .out_b   (b_pipe[s+1]),
                .out_y   (y_pipe[s+1]),
                .out_c   (c_pipe[s+1])
            );
        end
    endgenerate

    assign out_valid = vld_pipe[STAGES];
    assign y         = y_pipe[STAGES];
    assign cout      = c_pipe[STAGES];
    assign zero      = (y_pipe[STAGES] == '0);

    // Signed overflow: both effective operands share a sign and the result sign differs.
    assign overflow  = (a_pipe[STAGES][WIDTH-1] == b_pipe[STAGES][WIDTH-1])
                    && (y_pipe[STAGES][WIDTH-1] != a_pipe[STAGES][WIDTH-1]);

    // Only the operand MSBs are read at the last stage.
    assign unused_ops = ^{a_pipe[STAGES], b_pipe[STAGES]};
endmodule
